// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Holds the derived-constant helpers (slice width SW = WIDTH/STAGES and
// CLA group count NGRP = SW/BLOCK) and the parameter legality check used
// by the top level to refuse an impossible configuration at elaboration.
package cla_pipe_adder_pkg;

  localparam int WIDTH_DEFAULT  = 32'sd64;
  localparam int STAGES_DEFAULT = 32'sd4;
  localparam int BLOCK_DEFAULT  = 32'sd4;

  // Width of one pipeline slice (SW).
  function automatic int slice_width(input int width, input int stages);
    int sw;
    if (stages > 32'sd0) begin
      sw = width / stages;
    end else begin
      sw = 32'sd0;
    end
    return sw;
  endfunction

  // Number of BLOCK-wide lookahead groups inside one slice (NGRP).
  function automatic int group_count(input int sw, input int block);
    int ngrp;
    if (block > 32'sd0) begin
      ngrp = sw / block;
    end else begin
      ngrp = 32'sd0;
    end
    return ngrp;
  endfunction

  // True when WIDTH splits evenly into STAGES slices and each slice into BLOCK groups.
  function automatic bit params_legal(input int width, input int stages, input int block);
    bit ok;
    ok = 1'b0;
    if ((stages > 32'sd0) && (block > 32'sd0) && (width >= stages)) begin
      ok = ((width % stages) == 32'sd0) &&
           ((slice_width(width, stages) % block) == 32'sd0) &&
           (slice_width(width, stages) >= block);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SW-bit carry-lookahead slice.
// Ports:
//   a, b   : SW-bit operands (b already inverted by the caller for subtraction)
//   cin    : carry into bit 0
//   s      : SW-bit sum
//   cout   : carry out of bit SW-1
//   c_msb  : carry into bit SW-1 (lets the top slice derive signed overflow)
// Bits are grouped BLOCK-wide; each group forms a group generate/propagate
// pair and the group carries are resolved from those pairs, so the long
// carry path skips whole groups instead of rippling bit by bit.
module cla_slice
  import cla_pipe_adder_pkg::*;
#(
  parameter int SW    = 32'sd16,
  parameter int BLOCK = 32'sd4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          c_msb
);

  localparam int NGRP = group_count(SW, BLOCK);

  logic [SW-1:0]   g;
  logic [SW-1:0]   p;
  logic [NGRP-1:0] grp_g;
  logic [NGRP-1:0] grp_p;
  logic [NGRP:0]   gc;
  logic [SW:0]     c;

  // Bit and group generate/propagate, group carries, then per-bit carries and sum.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    grp_g = '0;
    grp_p = '0;
    gc    = '0;
    c     = '0;

    for (int k = 0; k < NGRP; k++) begin
      grp_g[k] = 1'b0;
      grp_p[k] = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        grp_g[k] = g[k*BLOCK + j] | (p[k*BLOCK + j] & grp_g[k]);
        grp_p[k] = grp_p[k] & p[k*BLOCK + j];
      end
    end

    gc[0] = cin;
    for (int k = 0; k < NGRP; k++) begin
      gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
    end

    // Inside a group the carries start from the resolved group carry-in.
    for (int k = 0; k < NGRP; k++) begin
      c[k*BLOCK] = gc[k];
      for (int j = 1; j < BLOCK; j++) begin
        c[k*BLOCK + j] = g[k*BLOCK + j - 1] | (p[k*BLOCK + j - 1] & c[k*BLOCK + j - 1]);
      end
    end
    c[SW] = gc[NGRP];

    s     = p ^ c[SW-1:0];
    cout  = c[SW];
    c_msb = c[SW-1];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   flush               : synchronous, drops every in-flight operation
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   sub                 : 1 computes a - b as a + ~b + 1 (cin ignored)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   cout                : carry out of the MSB (for subtraction 1 = no borrow)
//   ovf                 : signed overflow, carry into MSB xor carry out
// The add is split into STAGES slices of SW bits. Stage i adds slice i and
// registers the carry, the finished low result bits and the still unused
// high operand bits, so the carry ripples between slices through flops.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT,
  parameter int BLOCK  = BLOCK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES, BLOCK)) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be divisible by STAGES and WIDTH/STAGES by BLOCK");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] en;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

  // Subtraction feeds the inverted B operand and forces the carry-in to 1.
  always_comb begin
    if (sub) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end else begin
      b_eff   = b;
      cin_eff = cin;
    end
  end

  // Load enables, last stage first: a stage moves if it is empty or its successor moves.
  always_comb begin
    en             = '0;
    en[STAGES-1]   = ~v_q[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      en[i] = ~v_q[i] | en[i+1];
    end
  end

  // Valid bits follow the load enables; flush overrides every load.
  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (en[0]) begin
        v_d[0] = in_valid;
      end else begin
        v_d[0] = v_q[0];
      end
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) begin
          v_d[i] = v_q[i-1];
        end else begin
          v_d[i] = v_q[i];
        end
      end
    end
  end

  // Stage valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int LW = (i + 1) * SW;   // finished result bits held here
    localparam int RW = WIDTH - LW;     // operand bits still to be added

    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic          scin;
    logic [SW-1:0] s;
    logic          sc;
    logic          smsb;
    logic [LW-1:0] res_q;
    logic [LW-1:0] res_d;
    logic          c_q;
    logic          c_d;

    if (i == 0) begin : g_src
      // Slice 0 works directly on the offered operands.
      always_comb begin
        sa    = a[SW-1:0];
        sb    = b_eff[SW-1:0];
        scin  = cin_eff;
        res_d = s;
      end
    end else begin : g_src
      // Later slices take the operand bits and carry parked by the previous stage.
      always_comb begin
        sa    = g_stage[i-1].g_hold.opa_q[SW-1:0];
        sb    = g_stage[i-1].g_hold.opb_q[SW-1:0];
        scin  = g_stage[i-1].c_q;
        res_d = {s, g_stage[i-1].res_q};
      end
    end

    cla_slice #(
      .SW    (SW),
      .BLOCK (BLOCK)
    ) u_slice (
      .a     (sa),
      .b     (sb),
      .cin   (scin),
      .s     (s),
      .cout  (sc),
      .c_msb (smsb)
    );

    // Carry handed to the next slice.
    always_comb begin
      c_d = sc;
    end

    // Result and carry registers; frozen while the stage cannot advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
        c_q   <= 1'b0;
      end else if (en[i]) begin
        res_q <= res_d;
        c_q   <= c_d;
      end
    end

    if (i < STAGES - 1) begin : g_hold
      logic [RW-1:0] opa_q;
      logic [RW-1:0] opa_d;
      logic [RW-1:0] opb_q;
      logic [RW-1:0] opb_d;

      if (i == 0) begin : g_op
        // Park everything above slice 0.
        always_comb begin
          opa_d = a[WIDTH-1:SW];
          opb_d = b_eff[WIDTH-1:SW];
        end
      end else begin : g_op
        // Drop the slice just consumed and pass the rest along.
        always_comb begin
          opa_d = g_stage[i-1].g_hold.opa_q[RW+SW-1:SW];
          opb_d = g_stage[i-1].g_hold.opb_q[RW+SW-1:SW];
        end
      end

      // Pending high operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (en[i]) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end

    if (i == STAGES - 1) begin : g_last
      logic ovf_q;
      logic ovf_d;

      // Signed overflow from the top slice: carry into MSB differs from carry out.
      always_comb begin
        ovf_d = smsb ^ sc;
      end

      // Overflow flag register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en[i]) begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_mid
      // The carry into a slice MSB only matters for the top slice.
      logic unused_msb;
      always_comb begin
        unused_msb = smsb;
      end
    end
  end

  // Outputs come straight from the last stage registers.
  always_comb begin
    in_ready  = en[0];
    out_valid = v_q[STAGES-1];
    sum       = g_stage[STAGES-1].res_q;
    cout      = g_stage[STAGES-1].c_q;
    ovf       = g_stage[STAGES-1].g_last.ovf_q;
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed testbench for cla_pipe_adder (WIDTH=64, STAGES=4, BLOCK=4).
module tb_cla_pipe_adder;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(
    .WIDTH  (64),
    .STAGES (4),
    .BLOCK  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h", tag, obs, exp);
    end
  endtask

  // Reference result {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic su);
    logic [W-1:0] yy;
    logic [W:0]   t;
    logic         o;
    yy = su ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (su ? 1'b1 : ci)};
    o  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {o, t};
  endfunction

  // One isolated operation with out_ready=1: checks latency and result.
  task automatic run_single(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic xc, input logic xs, input logic [W-1:0] es,
                            input logic ec, input logic eo);
    @(posedge clk); #1;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, ".early"}, out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".ovf"}, ovf, eo);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".drained"}, out_valid, 1'b0);
  endtask

  logic [W-1:0] va [8] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
                           64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0010,
                           64'hDEAD_BEEF_CAFE_F00D, 64'h8000_0000_0000_0000,
                           64'h0F0F_0F0F_F0F0_F0F0, 64'h0000_FFFF_FFFF_0000};
  logic [W-1:0] vb [8] = '{64'hFEDC_BA98_7654_3210, 64'h0001_0000_0001_0000,
                           64'h0000_0000_0000_0001, 64'h0000_0000_0000_0020,
                           64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0000,
                           64'hF0F0_F0F0_0F0F_0F0F, 64'h0000_0000_0001_0000};
  logic         vc [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic         vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W+1:0] r;
    logic [W-1:0] prev_sum;
    logic [W-1:0] flush_exp;
    logic         prev_stall;
    logic         saw_block;
    int           acc;
    int           emit;
    int           n_out;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    #2;
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.sum", sum, 64'h0);
    check("rst.cout", cout, 1'b0);
    check("rst.ovf", ovf, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", in_ready, 1'b1);

    // Directed single operations
    run_single("add_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_single("sub_borrow", 64'h5, 64'h7, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_single("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
               64'h0, 1'b1, 1'b0);
    run_single("sub_cin_ign", 64'hA, 64'h3, 1'b1, 1'b1,
               64'h7, 1'b1, 1'b0);
    run_single("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_single("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // Back-to-back with backpressure in cycles 5-8
    acc = 0; emit = 0; prev_stall = 1'b0; prev_sum = '0; saw_block = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 5 && cyc <= 8);
      if (acc < 8) begin
        in_valid = 1'b1; a = va[acc]; b = vb[acc]; cin = vc[acc]; sub = vs[acc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b.in_ready", in_ready, (out_ready || ((acc - emit) < 4)));
      if (!in_ready) saw_block = 1'b1;
      if (prev_stall) check("b2b.hold", sum, prev_sum);
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      if (out_valid && out_ready) begin
        if (emit < 8) begin
          r = ref_op(va[emit], vb[emit], vc[emit], vs[emit]);
          check($sformatf("b2b.sum%0d", emit), sum, r[W-1:0]);
          check($sformatf("b2b.cout%0d", emit), cout, r[W]);
          check($sformatf("b2b.ovf%0d", emit), ovf, r[W+1]);
        end else begin
          check("b2b.extra", out_valid, 1'b0);
        end
        emit++;
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("b2b.count", W'(emit), 64'd8);
    check("b2b.blocked", saw_block, 1'b1);

    // Flush: ops in cycles 1-3, flush plus a dropped op in cycle 4, new op in cycle 5
    n_out = 0;
    r = ref_op(64'h0000_1000_0000_0001, 64'h0000_0200_0000_0002, 1'b0, 1'b0);
    flush_exp = r[W-1:0];
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      flush     = (cyc == 4);
      in_valid  = (cyc <= 5);
      a   = (cyc == 5) ? 64'h0000_1000_0000_0001 : 64'(cyc) << 20;
      b   = (cyc == 5) ? 64'h0000_0200_0000_0002 : 64'(cyc);
      cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (cyc == 4) check("flush.in_ready", in_ready, 1'b1);
      if (cyc == 5) check("flush.cleared", out_valid, 1'b0);
      if (out_valid) begin
        n_out++;
        check("flush.when", W'(cyc), 64'd9);
        check("flush.sum", sum, flush_exp);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
    check("flush.count", W'(n_out), 64'd1);

    // Async reset with a full, stalled pipeline
    @(posedge clk); #1;
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; a = 64'h1111 * 64'(k + 1); b = 64'h2222;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("arst.full_valid", out_valid, 1'b1);
    check("arst.full_ready", in_ready, 1'b0);
    check("arst.full_sum", sum, 64'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", out_valid, 1'b0);
    check("arst.sum", sum, 64'h0);
    check("arst.cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst.in_ready", in_ready, 1'b1);
    run_single("after_rst", 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
               64'h100, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
